// File: rtl/coherent_average_core_if.sv
// Sample-in / average-out bus of the coherent averager.
// The bench or upstream stage takes the master side; the core takes the slave side.
interface coherent_average_core_if #(
    parameter int DATA_W      = 16,
    parameter int LOG2_POINTS = 7
);
    logic                     enable;
    logic                     continuous;
    logic [3:0]               log2_frames;
    logic signed [DATA_W-1:0] din;
    logic                     din_valid;
    logic                     sync;
    logic signed [DATA_W-1:0] dout;
    logic                     dout_valid;
    logic [LOG2_POINTS-1:0]   dout_index;
    logic                     dout_last;
    logic                     busy;
    logic                     done;
    logic                     sync_err;

    modport master (
        output enable, continuous, log2_frames, din, din_valid, sync,
        input  dout, dout_valid, dout_index, dout_last, busy, done, sync_err
    );

    modport slave (
        input  enable, continuous, log2_frames, din, din_valid, sync,
        output dout, dout_valid, dout_index, dout_last, busy, done, sync_err
    );
endinterface

// File: rtl/coherent_average_core.sv
// Coherent averager: sums 2^k periods point by point in a dual-port RAM,
// then streams the averaged period out with index/last/done markers.
module coherent_average_core #(
    parameter int DATA_W          = 16,
    parameter int LOG2_POINTS     = 7,
    parameter int LOG2_FRAMES_MAX = 13,
    parameter int ROUND           = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    coherent_average_core_if.slave   bus
);
    localparam int AW = DATA_W + LOG2_FRAMES_MAX;
    localparam int PW = LOG2_POINTS;
    localparam int FW = LOG2_FRAMES_MAX;
    localparam logic [3:0]    KMAX    = 4'(LOG2_FRAMES_MAX);
    localparam logic [PW-1:0] PT_LAST = '1;

    typedef enum logic [2:0] {IDLE, WAIT_SYNC, ACCUM, DUMP, DONE} state_t;
    state_t state_q, state_d;

    logic [3:0]    k_q;
    logic          cont_q;
    logic [PW-1:0] pt_q, dp_q;
    logic [FW-1:0] fr_q;
    logic          full_q, sync_err_q;

    logic                     vld_p0, first_p0, last_p0;
    logic [PW-1:0]            pt_p0;
    logic signed [DATA_W-1:0] din_p0;
    logic                     vld_p1, first_p1, last_p1;
    logic [PW-1:0]            pt_p1;
    logic signed [DATA_W-1:0] din_p1;
    logic                     dvld_p1, dlast_p1;
    logic [PW-1:0]            didx_p1;

    logic signed [AW-1:0] mem [2**PW];
    logic signed [AW-1:0] rd_q;
    logic signed [AW-1:0] din_ext_p1;

    logic signed [DATA_W-1:0] dout_q;
    logic                     dout_valid_q, dout_last_q, busy_q, done_q;
    logic [PW-1:0]            dout_index_q;

    logic          in_run, abort, accept, pt_wrap, fr_last, final_acc;
    logic [FW:0]   nfr;
    logic [3:0]    k_in;
    logic [PW-1:0] rd_addr;

    function automatic logic signed [DATA_W-1:0] avg_f(input logic signed [AW-1:0] acc,
                                                       input logic [3:0] k);
        logic signed [AW-1:0] sum;
        sum = acc;
        if (ROUND != 0 && k != 4'd0)
            sum = acc + $signed(AW'(1) << (k - 4'd1));
        return DATA_W'(sum >>> k);
    endfunction

    always_comb begin
        in_run     = (state_q == WAIT_SYNC) || (state_q == ACCUM) || (state_q == DUMP);
        abort      = in_run && !bus.enable;
        accept     = bus.din_valid && !abort &&
                     (((state_q == WAIT_SYNC) && bus.sync) || ((state_q == ACCUM) && !full_q));
        pt_wrap    = (pt_q == PT_LAST);
        nfr        = ((FW+1)'(1) << k_q) - (FW+1)'(1);
        fr_last    = ({1'b0, fr_q} == nfr);
        final_acc  = accept && pt_wrap && fr_last;
        rd_addr    = (state_q == DUMP) ? dp_q : pt_p0;
        k_in       = (bus.log2_frames > KMAX) ? KMAX : bus.log2_frames;
        din_ext_p1 = $signed({{FW{din_p1[DATA_W-1]}}, din_p1});
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.enable) state_d = WAIT_SYNC;
            WAIT_SYNC: if (!bus.enable) state_d = IDLE;
                       else if (accept) state_d = ACCUM;
            // leave only once the final sample's write has landed
            ACCUM:     if (!bus.enable) state_d = IDLE;
                       else if (vld_p1 && last_p1) state_d = DUMP;
            DUMP:      if (!bus.enable) state_d = IDLE;
                       else if (dp_q == PT_LAST) state_d = cont_q ? WAIT_SYNC : DONE;
            DONE:      if (!bus.enable) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            cont_q       <= 1'b0;
            pt_q         <= '0;
            fr_q         <= '0;
            full_q       <= 1'b0;
            dp_q         <= '0;
            sync_err_q   <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            dvld_p1      <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_index_q <= '0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == WAIT_SYNC) || (state_d == ACCUM) || (state_d == DUMP);
            if (state_q == IDLE && bus.enable) begin
                k_q        <= k_in;
                cont_q     <= bus.continuous;
                sync_err_q <= 1'b0;
            end
            if (state_q == ACCUM && bus.din_valid && bus.sync && pt_q != '0 && !full_q)
                sync_err_q <= 1'b1;
            if (accept) begin
                pt_q <= pt_q + 1'b1;
                if (pt_wrap) fr_q <= fr_q + 1'b1;
                if (final_acc) full_q <= 1'b1;
            end else if (state_q == IDLE || state_q == DUMP || state_q == DONE) begin
                pt_q   <= '0;
                fr_q   <= '0;
                full_q <= 1'b0;
            end
            dp_q <= (state_q == DUMP) ? dp_q + 1'b1 : '0;
            // stage p0 -> p1: accumulate read issued, dump read issued
            vld_p0  <= accept;
            vld_p1  <= vld_p0 && !abort;
            dvld_p1 <= (state_q == DUMP) && !abort;
            // stage p1 -> output registers
            dout_valid_q <= dvld_p1 && !abort;
            dout_last_q  <= dvld_p1 && dlast_p1 && !abort;
            done_q       <= dvld_p1 && dlast_p1 && !abort;
            if (dvld_p1) begin
                dout_q       <= avg_f(rd_q, k_q);
                dout_index_q <= didx_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        din_p0   <= bus.din;
        pt_p0    <= pt_q;
        first_p0 <= (fr_q == '0);
        last_p0  <= final_acc;
        din_p1   <= din_p0;
        pt_p1    <= pt_p0;
        first_p1 <= first_p0;
        last_p1  <= last_p0;
        didx_p1  <= dp_q;
        dlast_p1 <= (dp_q == PT_LAST);
        rd_q     <= mem[rd_addr];
        // frame 0 overwrites, so stale data from an earlier run never leaks in
        if (vld_p1)
            mem[pt_p1] <= first_p1 ? din_ext_p1 : rd_q + din_ext_p1;
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_index = dout_index_q;
    assign bus.dout_last  = dout_last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_coherent_average_core.sv
// Directed bench for coherent_average_core: 8-point periods, up to 16 frames,
// with a floor build and a round-half-up build fed the same stream.
module tb_coherent_average_core;
    localparam int DW = 16, LP = 3, LFM = 4, NP = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    coherent_average_core_if #(.DATA_W(DW), .LOG2_POINTS(LP)) bus();
    coherent_average_core_if #(.DATA_W(DW), .LOG2_POINTS(LP)) bus_r();

    assign bus_r.enable      = bus.enable;
    assign bus_r.continuous  = bus.continuous;
    assign bus_r.log2_frames = bus.log2_frames;
    assign bus_r.din         = bus.din;
    assign bus_r.din_valid   = bus.din_valid;
    assign bus_r.sync        = bus.sync;

    coherent_average_core #(.DATA_W(DW), .LOG2_POINTS(LP), .LOG2_FRAMES_MAX(LFM), .ROUND(0))
        dut (.clk(clk), .reset(reset), .bus(bus));
    coherent_average_core #(.DATA_W(DW), .LOG2_POINTS(LP), .LOG2_FRAMES_MAX(LFM), .ROUND(1))
        dut_r (.clk(clk), .reset(reset), .bus(bus_r));

    int n_pass = 0, n_total = 0;
    int got_d[NP], got_i[NP], got_l[NP], got_n[NP], got_v[NP], got_r[NP];
    bit timed_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] lf, input logic cont);
        bus.log2_frames = lf;
        bus.continuous  = cont;
        bus.enable      = 1'b1;
        tick();
    endtask

    task automatic stop();
        bus.enable = 1'b0;
        tick();
    endtask

    // kind 0: constant val; 1: ramp p-4; 2: ramp with point 0 = +1/-2 by frame;
    // 3: constant val plus a stray sync at point 5 of frame 1
    task automatic feed(input int frames, input int kind, input int val);
        for (int f = 0; f < frames; f++) begin
            for (int p = 0; p < NP; p++) begin
                bus.din_valid = 1'b1;
                bus.sync      = (p == 0) || (kind == 3 && f == 1 && p == 5);
                case (kind)
                    1:       bus.din = 16'(p - 4);
                    2:       bus.din = (p == 0) ? ((f % 2 == 0) ? 16'sd1 : -16'sd2) : 16'(p - 4);
                    default: bus.din = 16'(val);
                endcase
                tick();
            end
        end
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
    endtask

    task automatic collect();
        timed_out = 1'b0;
        for (int c = 0; c < 100 && !bus.dout_valid; c++) tick();
        if (!bus.dout_valid) timed_out = 1'b1;
        for (int i = 0; i < NP; i++) begin
            got_d[i] = bus.dout;
            got_i[i] = bus.dout_index;
            got_l[i] = bus.dout_last;
            got_n[i] = bus.done;
            got_v[i] = bus.dout_valid;
            got_r[i] = bus_r.dout;
            tick();
        end
    endtask

    task automatic test_reset();
        bus.enable = 0; bus.continuous = 0; bus.log2_frames = 0;
        bus.din = 0; bus.din_valid = 0; bus.sync = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({bus.dout, bus.dout_valid, bus.dout_index, bus.dout_last, bus.busy, bus.done, bus.sync_err} !== '0)
            $display("FAIL reset_outputs got %h required 0",
                     {bus.dout, bus.dout_valid, bus.dout_index, bus.dout_last, bus.busy, bus.done, bus.sync_err});
        else n_pass++;
        reset = 1'b0;
        tick();
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL idle_busy got %b required 0", bus.busy); else n_pass++;
    endtask

    task automatic test_single_shot();
        int cnt;
        start(4'd2, 1'b0);
        n_total++;
        if (bus.busy !== 1'b1) $display("FAIL busy_rise got %b required 1", bus.busy); else n_pass++;
        feed(4, 0, 100);
        collect();
        n_total++;
        if (timed_out) $display("FAIL single_timeout got timeout required dout_valid"); else n_pass++;
        for (int i = 0; i < NP; i++) begin
            n_total++;
            if (got_d[i] !== 100 || got_v[i] !== 1)
                $display("FAIL single_dout[%0d] got %0d/v%0d required 100/v1", i, got_d[i], got_v[i]);
            else n_pass++;
            n_total++;
            if (got_i[i] !== i || got_l[i] !== int'(i == NP-1) || got_n[i] !== int'(i == NP-1))
                $display("FAIL single_marks[%0d] got idx%0d last%0d done%0d required idx%0d last%0d done%0d",
                         i, got_i[i], got_l[i], got_n[i], i, i == NP-1, i == NP-1);
            else n_pass++;
        end
        n_total++;
        if ({bus.dout_valid, bus.done, bus.busy} !== 3'b000)
            $display("FAIL single_after got %b required 000", {bus.dout_valid, bus.done, bus.busy});
        else n_pass++;
        // still enabled in DONE: new samples must not start another run
        feed(1, 0, 5);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.dout_valid || bus.busy) cnt++;
            tick();
        end
        n_total++;
        if (cnt !== 0) $display("FAIL single_no_rerun got %0d active cycles required 0", cnt); else n_pass++;
        stop();
    endtask

    task automatic test_ramp();
        start(4'd3, 1'b0);
        feed(8, 1, 0);
        collect();
        n_total++;
        if (timed_out) $display("FAIL ramp_timeout got timeout required dout_valid"); else n_pass++;
        for (int i = 0; i < NP; i++) begin
            n_total++;
            if (got_d[i] !== i - 4 || got_r[i] !== i - 4)
                $display("FAIL ramp_dout[%0d] got %0d/%0d required %0d", i, got_d[i], got_r[i], i - 4);
            else n_pass++;
        end
        n_total++;
        if (bus.sync_err !== 1'b0) $display("FAIL ramp_sync_err got %b required 0", bus.sync_err); else n_pass++;
        stop();
        start(4'd3, 1'b0);
        feed(8, 2, 0);
        collect();
        n_total++;
        if (got_d[0] !== -1) $display("FAIL floor_pt0 got %0d required -1", got_d[0]); else n_pass++;
        n_total++;
        if (got_r[0] !== 0) $display("FAIL round_pt0 got %0d required 0", got_r[0]); else n_pass++;
        n_total++;
        if (got_d[1] !== -3) $display("FAIL mixed_pt1 got %0d required -3", got_d[1]); else n_pass++;
        stop();
    endtask

    task automatic test_sync_err();
        start(4'd2, 1'b0);
        feed(4, 3, 100);
        n_total++;
        if (bus.sync_err !== 1'b1) $display("FAIL sync_err_set got %b required 1", bus.sync_err); else n_pass++;
        collect();
        for (int i = 0; i < NP; i++) begin
            n_total++;
            if (got_d[i] !== 100 || got_i[i] !== i)
                $display("FAIL sync_err_dout[%0d] got %0d idx%0d required 100 idx%0d", i, got_d[i], got_i[i], i);
            else n_pass++;
        end
        stop();
        n_total++;
        if (bus.sync_err !== 1'b1) $display("FAIL sync_err_sticky got %b required 1", bus.sync_err); else n_pass++;
        start(4'd2, 1'b0);
        n_total++;
        if (bus.sync_err !== 1'b0) $display("FAIL sync_err_clear got %b required 0", bus.sync_err); else n_pass++;
        stop();
    endtask

    task automatic test_continuous();
        start(4'd1, 1'b1);
        feed(2, 0, 50);
        collect();
        for (int i = 0; i < NP; i++) begin
            n_total++;
            if (got_d[i] !== 50 || got_n[i] !== int'(i == NP-1))
                $display("FAIL cont_a[%0d] got %0d done%0d required 50 done%0d", i, got_d[i], got_n[i], i == NP-1);
            else n_pass++;
        end
        n_total++;
        if (bus.busy !== 1'b1) $display("FAIL cont_busy got %b required 1", bus.busy); else n_pass++;
        feed(2, 0, -50);
        collect();
        n_total++;
        if (timed_out) $display("FAIL cont_timeout got timeout required dout_valid"); else n_pass++;
        for (int i = 0; i < NP; i++) begin
            n_total++;
            if (got_d[i] !== -50) $display("FAIL cont_b[%0d] got %0d required -50", i, got_d[i]); else n_pass++;
        end
        stop();
        n_total++;
        if ({bus.busy, bus.dout_valid} !== 2'b00)
            $display("FAIL cont_stop got %b required 00", {bus.busy, bus.dout_valid});
        else n_pass++;
    endtask

    task automatic test_abort();
        int cnt;
        start(4'd2, 1'b0);
        feed(2, 0, 100);
        stop();
        n_total++;
        if ({bus.dout_valid, bus.done, bus.busy} !== 3'b000)
            $display("FAIL abort_accum got %b required 000", {bus.dout_valid, bus.done, bus.busy});
        else n_pass++;
        start(4'd2, 1'b0);
        feed(4, 0, 7);
        collect();
        for (int i = 0; i < NP; i++) begin
            n_total++;
            if (got_d[i] !== 7) $display("FAIL abort_rerun[%0d] got %0d required 7", i, got_d[i]); else n_pass++;
        end
        stop();
        start(4'd2, 1'b0);
        feed(4, 0, 9);
        for (int c = 0; c < 100 && !bus.dout_valid; c++) tick();
        tick();
        tick();
        n_total++;
        if (bus.dout_valid !== 1'b1) $display("FAIL abort_dump_pre got %b required 1", bus.dout_valid); else n_pass++;
        stop();
        n_total++;
        if ({bus.dout_valid, bus.done, bus.busy} !== 3'b000)
            $display("FAIL abort_dump got %b required 000", {bus.dout_valid, bus.done, bus.busy});
        else n_pass++;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.dout_valid || bus.done) cnt++;
            tick();
        end
        n_total++;
        if (cnt !== 0) $display("FAIL abort_dump_quiet got %0d required 0", cnt); else n_pass++;
        start(4'd2, 1'b0);
        feed(4, 0, -9);
        collect();
        for (int i = 0; i < NP; i++) begin
            n_total++;
            if (got_d[i] !== -9 || got_n[i] !== int'(i == NP-1))
                $display("FAIL abort_clean[%0d] got %0d done%0d required -9 done%0d", i, got_d[i], got_n[i], i == NP-1);
            else n_pass++;
        end
        stop();
    endtask

    task automatic test_async_reset();
        start(4'd2, 1'b0);
        feed(4, 0, 33);
        for (int c = 0; c < 100 && !bus.dout_valid; c++) tick();
        n_total++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 16'sd33)
            $display("FAIL areset_pre got v%b %0d required v1 33", bus.dout_valid, bus.dout);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({bus.dout, bus.dout_valid, bus.dout_index, bus.dout_last, bus.busy, bus.done, bus.sync_err} !== '0)
            $display("FAIL areset_outputs got %h required 0",
                     {bus.dout, bus.dout_valid, bus.dout_index, bus.dout_last, bus.busy, bus.done, bus.sync_err});
        else n_pass++;
        bus.enable = 1'b0;
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_clamp();
        start(4'd15, 1'b0);
        feed(16, 0, -32768);
        collect();
        n_total++;
        if (timed_out) $display("FAIL clamp_timeout got timeout required dout_valid"); else n_pass++;
        for (int i = 0; i < NP; i++) begin
            n_total++;
            if (got_d[i] !== -32768 || got_r[i] !== -32768 || got_l[i] !== int'(i == NP-1))
                $display("FAIL clamp_dout[%0d] got %0d/%0d last%0d required -32768 last%0d",
                         i, got_d[i], got_r[i], got_l[i], i == NP-1);
            else n_pass++;
        end
        stop();
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_ramp();
        test_sync_err();
        test_continuous();
        test_abort();
        test_async_reset();
        test_clamp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/coherent_average_core.md
# coherent_average_core

Parametrised coherent averager: accumulates 2^k consecutive periods of a sample stream point by point, then streams out the averaged period. It sits between the ADC/sample-rate stage and the lock-in demodulator in the coherent-average/lock-in datapath. It generalises the fixed 128-point/8192-frame averager in three ways: configurable width and depth, a run-time frame count, and single-shot or continuous operation.

## Interface

Parameters:
- DATA_W, 16, signed sample width in and out.
- LOG2_POINTS, 7, log2 of samples per period; must be ≥ 2.
- LOG2_FRAMES_MAX, 13, maximum log2 frame count; accumulator width is DATA_W+LOG2_FRAMES_MAX.
- ROUND, 0, 1 = round-half-up before the output shift; 0 = floor (arithmetic shift).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; deassertion aborts.
- continuous  in  1  1 = restart after each dump; 0 = single shot. Sampled when leaving IDLE.
- log2_frames  in  4  frames to average = 2^log2_frames. Sampled when leaving IDLE; values > LOG2_FRAMES_MAX are clamped.
- din  in  DATA_W  signed sample.
- din_valid  in  1  sample qualifier.
- sync  in  1  period marker, qualified by din_valid; the marked sample is point 0.
- dout  out  DATA_W  signed averaged sample.
- dout_valid  out  1  output qualifier.
- dout_index  out  LOG2_POINTS  point index of dout.
- dout_last  out  1  high with the final point of a dump.
- busy  out  1  high in any state other than IDLE or DONE.
- done  out  1  one-cycle pulse coincident with dout_last.
- sync_err  out  1  sticky flag: sync arrived at point ≠ 0 during ACCUM. Cleared only by reset or by leaving IDLE.

## Operation

- Storage: one simple dual-port RAM of 2^LOG2_POINTS words, each DATA_W+LOG2_FRAMES_MAX bits, with 1-cycle read latency.
- FSM states: IDLE, WAIT_SYNC, ACCUM, DUMP, DONE.
- IDLE → WAIT_SYNC on enable=1. Latches log2_frames and continuous; clears sync_err.
- WAIT_SYNC → ACCUM on the first din_valid&&sync. That sample is accumulated as point 0 of frame 0.
- ACCUM, per valid sample:
  - point counter increments and wraps at 2^LOG2_POINTS−1; the frame counter increments on wrap.
  - Frame 0 writes sign-extended din directly, so no RAM clear is needed. Later frames do read-modify-write: mem[p] += din.
  - After the last point of frame 2^k−1 is accepted, go to DUMP.
- sync handling in ACCUM:
  - sync at point ≠ 0 sets sync_err; accumulation does not realign.
  - sync at point 0 is a no-op.
- Read/write hazard: consecutive samples always target different points (LOG2_POINTS ≥ 2), so the RMW pipeline needs no forwarding. The final write must complete before DUMP issues its first read.
- DUMP:
  - reads points 0..2^LOG2_POINTS−1, one per cycle.
  - dout = (acc + (ROUND ? 2^(k−1) : 0)) >>> k, truncated to DATA_W. Since |avg| ≤ max |din|, no saturation is needed. With k = 0, dout = din.
  - din is ignored during DUMP.
- After DUMP:
  - continuous=1 → WAIT_SYNC. The next acquisition re-aligns on sync and overwrites via the frame-0 rule.
  - continuous=0 → DONE.
- DONE → IDLE when enable=0.
- enable=0 in WAIT_SYNC, ACCUM or DUMP: go to IDLE next cycle, discard accumulation, drop dout_valid immediately, and do not pulse done.
- Reset: state IDLE; all counters and outputs 0 (dout, dout_valid, dout_index, dout_last, busy, done, sync_err).

## Timing

- Accumulate pipeline: 2 cycles from din_valid to RAM write. Samples are accepted every cycle with no stalls.
- ACCUM→DUMP transition: at most 2 cycles after the final accepted sample.
- Output: first dout_valid 2 cycles after entering DUMP. Then 2^LOG2_POINTS consecutive valid cycles with dout_index 0,1,…; dout_last and done on the final one.
- Input is dead during DUMP plus the following WAIT_SYNC: 2^LOG2_POINTS+3 cycles minimum.
- Total single-shot latency from the accepted sync to done: 2^(LOG2_POINTS+k) valid samples + 4 cycles + 2^LOG2_POINTS.
- All outputs are registered. busy rises the cycle after enable is seen in IDLE.

## Test plan

1. LOG2_POINTS=3, log2_frames=2, single shot.
   - Stimulus: constant din=100 every cycle, sync every 8 samples.
   - Expected: 8 outputs of 100, index 0..7, dout_last/done on index 7, busy low after. A second enable cycle is required to rerun.
2. Ramp din=p−4 (p = point index), log2_frames=3, ROUND=0.
   - Expected: outputs −4..3 exactly.
   - Then alternate +1/−2 per frame at point 0 (sum −4, k=3): dout[0] = −1 with floor; a ROUND=1 build yields 0.
3. Sync misplaced at point 5 during ACCUM.
   - Expected: sync_err=1 and stays set; outputs still correct relative to the original alignment.
   - sync_err clears on the next IDLE→WAIT_SYNC.
4. continuous=1, log2_frames=1, constant din alternating 50 then −50 per acquisition.
   - Expected: successive dumps of 50 and −50, with no stale data from the prior acquisition.
5. enable=0 mid-ACCUM, and separately mid-DUMP (after 3 outputs).
   - Expected: dout_valid low the next cycle, no done, busy=0.
   - Re-enable yields a clean full result.
   - Asynchronous reset mid-DUMP forces all outputs to 0 within the same cycle.
6. Full-scale corner: LOG2_POINTS=7, log2_frames=15 (clamped to 13).
   - Stimulus: din=−32768 constantly.
   - Expected: dout=−32768 for all 128 points, no wrap; done after 8192×128 samples.
